series_to_parrel_sync: RTL

SERIES_TO_PARREL_SYNC -- requirements
Module: series_to_parrel_sync

---
 rtl/series_to_parrel_pkg.sv | 19 +
 rtl/sp_shift_reg.sv | 48 ++++
 rtl/series_to_parrel_sync.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/series_to_parrel_pkg.sv
// series_to_parrel_pkg
// Shared definitions for the serial-to-parallel frame synchroniser:
//   - sp_state_e      : frame-sync FSM state encoding (HUNT / DATA / CHECK)
//   - SP_DEFAULT_SYNC : default frame sync pattern (low WIDTH bits are used)
//   - SP_MSB_FIRST / SP_LSB_FIRST : bit-order selector values for MSB_FIRST
package series_to_parrel_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } sp_state_e;

  localparam logic [31:0] SP_DEFAULT_SYNC = 32'h0000_EB90;

  localparam int SP_MSB_FIRST = 1;
  localparam int SP_LSB_FIRST = 0;

endpackage

// File: rtl/sp_shift_reg.sv
// sp_shift_reg
// WIDTH-bit shift window with selectable direction. With MSB_FIRST the
// oldest bit drifts towards q[WIDTH-1]; otherwise towards q[0]. After WIDTH
// shifts the first bit of a word therefore sits in the selected end.
// Ports:
//   clk_16   in   clock, rising edge
//   reset    in   synchronous active-high clear (wins over shift_en)
//   shift_en in   shift one bit in this cycle
//   din      in   serial bit to shift in
//   q        out  current window contents
module sp_shift_reg
  import series_to_parrel_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = SP_MSB_FIRST
) (
  input  logic             clk_16,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] win_q;
  logic [WIDTH-1:0] win_d;

  always_comb begin
    win_d = win_q;
    if (shift_en) begin
      if (MSB_FIRST == SP_MSB_FIRST) begin
        win_d = {win_q[WIDTH-2:0], din};
      end else begin
        win_d = {din, win_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_16) begin
    if (reset) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign q = win_q;

endmodule

// File: rtl/series_to_parrel_sync.sv
// series_to_parrel_sync
// Serial-to-parallel converter with frame synchronisation. A frame is a
// sync word followed by FRAME_WORDS data words. The receiver hunts for the
// sync pattern in a sliding window, then delivers each data word on sig_use
// with a one-cycle word_valid pulse, and verifies the sync word at the end of
// every frame. MAX_MISS consecutive bad syncs drop lock and restart the hunt;
// fewer misses are bridged (flywheel) while locked stays high.
//
// Optional feature (macro SP_PARITY_EN): every data word is followed by one
// even-parity bit; parity_err pulses with word_valid on an odd popcount of
// data+parity. Sync words never carry parity. When the macro is undefined
// parity_err is constant 0.
//
// Ports:
//   clk_16     in   single clock, all logic on the rising edge
//   reset      in   synchronous active-high reset
//   sig_reb    in   serial data, sampled only when bit_en=1
//   bit_en     in   one-cycle bit sample strobe
//   sig_use    out  last assembled data word, held between updates
//   word_valid out  one-cycle pulse when sig_use is updated
//   locked     out  high while frame-locked
//   parity_err out  parity failure pulse, coincident with word_valid
module series_to_parrel_sync
  import series_to_parrel_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(SP_DEFAULT_SYNC),
  parameter int               FRAME_WORDS = 4,
  parameter int               MAX_MISS    = 2,
  parameter int               MSB_FIRST   = SP_MSB_FIRST
) (
  input  logic             clk_16,
  input  logic             reset,
  input  logic             sig_reb,
  input  logic             bit_en,
  output logic [WIDTH-1:0] sig_use,
  output logic             word_valid,
  output logic             locked,
  output logic             parity_err
);

`ifdef SP_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Bits per data word on the line (data plus optional parity bit).
  localparam int DW      = WIDTH + PAR_BITS;
  localparam int BIT_CW  = $clog2(DW) + 1;
  localparam int WORD_CW = $clog2(FRAME_WORDS) + 1;
  localparam int MISS_CW = $clog2(MAX_MISS) + 1;

  sp_state_e            state_q, state_d;
  logic [BIT_CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_CW-1:0]   word_cnt_q, word_cnt_d;
  logic [MISS_CW-1:0]   miss_cnt_q, miss_cnt_d;
  logic [WIDTH-1:0]     sig_use_q, sig_use_d;
  logic                 word_valid_q, word_valid_d;
  logic                 locked_q, locked_d;
`ifdef SP_PARITY_EN
  logic [WIDTH-1:0]     hold_q, hold_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic [WIDTH-1:0]     win_q;
  logic [WIDTH-1:0]     win_next;
  logic                 sync_hit;
  logic                 bit_last_data;
  logic                 bit_last_word;
  logic                 word_last;
  logic [MISS_CW-1:0]   miss_inc;
  logic                 miss_limit;

  sp_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk_16   (clk_16),
    .reset    (reset),
    .shift_en (bit_en),
    .din      (sig_reb),
    .q        (win_q)
  );

  // Window as it will look after the current bit is shifted in; sync
  // detection and word capture act on the same edge that samples the bit.
  always_comb begin
    if (MSB_FIRST == SP_MSB_FIRST) begin
      win_next = {win_q[WIDTH-2:0], sig_reb};
    end else begin
      win_next = {sig_reb, win_q[WIDTH-1:1]};
    end
  end

  assign sync_hit      = (win_next == SYNC_WORD);
  assign bit_last_data = (bit_cnt_q == BIT_CW'(WIDTH - 1));
  assign bit_last_word = (bit_cnt_q == BIT_CW'(DW - 1));
  assign word_last     = (word_cnt_q == WORD_CW'(FRAME_WORDS - 1));
  assign miss_inc      = miss_cnt_q + 1'b1;
  assign miss_limit    = (miss_inc == MISS_CW'(MAX_MISS));

  // State register
  always_ff @(posedge clk_16) begin
    if (reset) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; nothing moves without a bit strobe.
  always_comb begin
    state_d = state_q;
    if (bit_en) begin
      case (state_q)
        ST_HUNT: begin
          if (sync_hit) state_d = ST_DATA;
        end
        ST_DATA: begin
          if (bit_last_word && word_last) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (bit_last_data) begin
            state_d = (sync_hit || !miss_limit) ? ST_DATA : ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Counters and output next-state logic.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    sig_use_d    = sig_use_q;
    word_valid_d = 1'b0;
    locked_d     = locked_q;
`ifdef SP_PARITY_EN
    hold_d       = hold_q;
    parity_err_d = 1'b0;
`endif
    if (bit_en) begin
      case (state_q)
        ST_HUNT: begin
          if (sync_hit) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            miss_cnt_d = '0;
            locked_d   = 1'b1;
          end
        end
        ST_DATA: begin
          bit_cnt_d = bit_last_word ? '0 : bit_cnt_q + 1'b1;
          if (bit_last_word) begin
            word_cnt_d = word_last ? '0 : word_cnt_q + 1'b1;
          end
`ifdef SP_PARITY_EN
          // Data bits are parked while the trailing parity bit arrives.
          if (bit_last_data) hold_d = win_next;
          if (bit_last_word) begin
            sig_use_d    = hold_q;
            word_valid_d = 1'b1;
            parity_err_d = ^{hold_q, sig_reb};
          end
`else
          if (bit_last_word) begin
            sig_use_d    = win_next;
            word_valid_d = 1'b1;
          end
`endif
        end
        ST_CHECK: begin
          if (bit_last_data) begin
            bit_cnt_d = '0;
            if (sync_hit) begin
              miss_cnt_d = '0;
            end else if (miss_limit) begin
              miss_cnt_d = '0;
              locked_d   = 1'b0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: begin
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_16) begin
    if (reset) begin
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      miss_cnt_q   <= '0;
      sig_use_q    <= '0;
      word_valid_q <= 1'b0;
      locked_q     <= 1'b0;
`ifdef SP_PARITY_EN
      hold_q       <= '0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      sig_use_q    <= sig_use_d;
      word_valid_q <= word_valid_d;
      locked_q     <= locked_d;
`ifdef SP_PARITY_EN
      hold_q       <= hold_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign sig_use    = sig_use_q;
  assign word_valid = word_valid_q;
  assign locked     = locked_q;
`ifdef SP_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
